// File: rtl/arb_mux_nto1_reg.sv
// N-input, W-bit registered selector with valid/ready handshakes.
// Selection is either by an external select port (MODE 0) or round-robin arbitration (MODE 1).
module arb_mux_nto1_reg #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_IN = 4,
  parameter  int MODE   = 0,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_src;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_rr_last;

  logic             w_gnt_vld;
  logic [SEL_W-1:0] w_gnt_idx;
  logic             w_accept;
  logic             w_xfer_in;
  logic [WIDTH-1:0] w_sel_data;

  // An in-flight reset also blocks acceptance so no handshake completes during it.
  assign w_accept  = resetn && !flush && (!r_out_valid || out_ready);
  assign w_xfer_in = w_gnt_vld && w_accept;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (MODE == 0) begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      // Wrapped search from rr_last+1: first the channels above rr_last, then from 0 upward.
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (!w_gnt_vld && in_valid[i] && SEL_W'(i) > r_rr_last) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = SEL_W'(i);
        end
      end
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (!w_gnt_vld && in_valid[i] && SEL_W'(i) <= r_rr_last) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    in_ready   = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (w_gnt_idx == SEL_W'(i)) begin
        w_sel_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = w_xfer_in;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_valid <= 1'b0;
      r_rr_last   <= SEL_W'(NUM_IN - 1);
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_xfer_in) begin
      r_out_data  <= w_sel_data;
      r_out_src   <= w_gnt_idx;
      r_out_valid <= 1'b1;
      r_rr_last   <= w_gnt_idx;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_valid = r_out_valid;

endmodule
